// File: rtl/clk_div_pkg.sv
// Shared types and limits for the clock divider bank.
// Channels are configured at run time; each one divides the 100 MHz system clock.
package clk_div_pkg;

  typedef enum logic {
    DIV_TOGGLE = 1'b0,
    DIV_PULSE  = 1'b1
  } div_mode_e;

  localparam int MAX_CHANNELS = 16;

  // Width of a channel index; stays at least 1 so a single-channel bank still has a cfg_ch bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: wrap counter, active/shadow configuration and registered outputs.
// A shadowed configuration takes effect only at a wrap, on disable or on sync, so outputs never glitch.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int          DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic             pending,
  output logic             tick,
  output logic             divided_clk
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] shadow_div;
  div_mode_e        mode;
  div_mode_e        shadow_mode;

  logic wrap;
  logic apply;
  logic mode_change;

  assign wrap        = (cnt == div);
  assign apply       = pending && (sync || !en || wrap);
  assign mode_change = apply && (shadow_mode != mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      div         <= DIV_W'(DEFAULT_DIV);
      mode        <= DIV_TOGGLE;
      shadow_div  <= DIV_W'(DEFAULT_DIV);
      shadow_mode <= DIV_TOGGLE;
      pending     <= 1'b0;
      tick        <= 1'b0;
      divided_clk <= 1'b0;
    end else begin
      // load is gated by cfg_ready upstream, so it never coincides with apply.
      if (apply) begin
        div     <= shadow_div;
        mode    <= shadow_mode;
        pending <= 1'b0;
      end else if (load) begin
        shadow_div  <= cfg_div;
        shadow_mode <= div_mode_e'(cfg_mode);
        pending     <= 1'b1;
      end

      if (sync || !en) begin
        cnt         <= '0;
        tick        <= 1'b0;
        divided_clk <= 1'b0;
      end else if (wrap) begin
        cnt  <= '0;
        tick <= 1'b1;
        if (mode_change) begin
          divided_clk <= 1'b0;
        end else if (mode == DIV_PULSE) begin
          divided_clk <= 1'b1;
        end else begin
          divided_clk <= ~divided_clk;
        end
      end else begin
        cnt  <= cnt + DIV_W'(1);
        tick <= 1'b0;
        if (mode == DIV_PULSE) begin
          divided_clk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent run-time programmable clock dividers with a shared valid/ready config port.
// Handshake: a request transfers on any edge where cfg_valid && cfg_ready; cfg_ready depends only on cfg_ch and registered pending flags.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int          CHANNELS    = 4,
  parameter int          DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = 1,
  localparam int         CH_W        = ch_idx_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                cfg_mode,
  output logic [CHANNELS-1:0] divided_clk,
  output logic [CHANNELS-1:0] tick
);

  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("clk_div_bank: CHANNELS must be in 1..16");
  end

  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] load;

  // An out-of-range channel is always ready so the request is silently dropped.
  always_comb begin
    cfg_ready = 1'b1;
    load      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(cfg_ch) == i) begin
        cfg_ready = ~pending[i];
        load[i]   = cfg_valid & ~pending[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clk_div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en[g]),
      .sync        (sync),
      .load        (load[g]),
      .cfg_div     (cfg_div),
      .cfg_mode    (cfg_mode),
      .pending     (pending[g]),
      .tick        (tick[g]),
      .divided_clk (divided_clk[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: driver pushes predicted outputs, monitor pops and compares each cycle.
// Three channels are instantiated so that cfg_ch = 3 is a representable out-of-range index.
module tb_clk_div_bank;

  localparam int          CH      = 3;
  localparam int          DIV_W   = 32;
  localparam int          CH_W    = 2;
  localparam int unsigned DEF_DIV = 1;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic [CH-1:0]    en        = '0;
  logic             sync      = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CH_W-1:0]  cfg_ch    = '0;
  logic [DIV_W-1:0] cfg_div   = '0;
  logic             cfg_mode  = 1'b0;
  logic             cfg_ready;
  logic [CH-1:0]    divided_clk;
  logic [CH-1:0]    tick;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2*CH:0] exp_q[$];

  clk_div_bank #(
    .CHANNELS    (CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sync        (sync),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_mode    (cfg_mode),
    .divided_clk (divided_clk),
    .tick        (tick)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endfunction

  // ---------------- reference model ----------------
  // Each channel runs in "segments": a segment starts at reset, sync, disable or an applied config.
  // Within a segment, edge n (1-based) ticks when n is a multiple of div+1; the toggle level flips per completed period.
  longint      m_n[CH];
  int unsigned m_div[CH], m_sdiv[CH];
  bit          m_mode[CH], m_smode[CH], m_l0[CH], m_pend[CH];
  bit [CH-1:0] m_tick, m_clk;

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_n[i] = 0; m_div[i] = DEF_DIV; m_sdiv[i] = DEF_DIV;
      m_mode[i] = 0; m_smode[i] = 0; m_l0[i] = 0; m_pend[i] = 0;
    end
    m_tick = '0;
    m_clk  = '0;
  endfunction

  function automatic bit model_ready(input int ch);
    return (ch >= CH) ? 1'b1 : !m_pend[ch];
  endfunction

  function automatic void model_edge(input bit [CH-1:0] e, input bit s, input bit v,
                                     input int ch, input int unsigned d, input bit m);
    bit xfer;
    xfer = v && (ch < CH) && model_ready(ch);
    for (int i = 0; i < CH; i++) begin
      longint per;
      per = longint'(m_div[i]) + 1;
      if (s || !e[i]) begin
        m_n[i] = 0; m_l0[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
        if (m_pend[i]) begin
          m_div[i] = m_sdiv[i]; m_mode[i] = m_smode[i]; m_pend[i] = 0;
        end
      end else begin
        m_n[i]++;
        m_tick[i] = (m_n[i] % per == 0);
        m_clk[i]  = m_mode[i] ? m_tick[i] : (m_l0[i] ^ bit'((m_n[i] / per) & 1));
        if (m_tick[i] && m_pend[i]) begin
          if (m_smode[i] != m_mode[i]) m_clk[i] = 0;
          m_div[i] = m_sdiv[i]; m_mode[i] = m_smode[i]; m_pend[i] = 0;
          m_n[i] = 0; m_l0[i] = m_clk[i];
        end
      end
    end
    if (xfer) begin
      m_sdiv[ch] = d; m_smode[ch] = m; m_pend[ch] = 1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [CH-1:0] e, input logic s, input logic v,
                       input int ch, input int unsigned d, input logic m);
    @(negedge clk);
    en = e; sync = s; cfg_valid = v; cfg_ch = CH_W'(ch); cfg_div = d; cfg_mode = m;
    model_edge(e, s, v, ch, d, m);
    exp_q.push_back({model_ready(ch), m_tick, m_clk});
  endtask

  task automatic run(input int n, input logic [CH-1:0] e);
    for (int k = 0; k < n; k++) drive(e, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // Holds cfg_valid until the request transfers (bounded).
  task automatic cfg(input logic [CH-1:0] e, input int ch, input int unsigned d, input logic m);
    bit done;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      done = model_ready(ch);
      drive(e, 1'b0, 1'b1, ch, d, m);
    end
    n_checks++;
    if (done) n_pass++;
    else $display("FAIL cfg_transfer ch%0d: got no transfer within 200 cycles, required transfer", ch);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      logic [2*CH:0] e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ready_tick_clk", 32'({cfg_ready, tick, divided_clk}), 32'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit hit;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_tick", 32'(tick), 32'(0));
    check("reset_divided_clk", 32'(divided_clk), 32'(0));
    check("reset_cfg_ready", 32'(cfg_ready), 32'(1));
    rst_n = 1'b1;

    // Default div=1 on every channel: period 4, tick every 2 cycles.
    run(12, '1);

    // ch1 -> div=4 PULSE while running.
    cfg('1, 1, 4, 1'b1);
    run(16, '1);

    // Two back-to-back requests for ch2; the second stalls until the first applies.
    cfg('1, 2, 3, 1'b0);
    cfg('1, 2, 6, 1'b1);
    run(20, '1);

    // ch0 at div=9, disabled mid-count, reprogrammed to div=2, re-enabled.
    cfg('1, 0, 9, 1'b0);
    run(15, '1);
    run(3, 3'b110);
    cfg(3'b110, 0, 2, 1'b0);
    run(3, 3'b110);
    run(12, '1);

    // ch0 div=3, ch1 div=5 TOGGLE; sync on the edge where ch0 wraps.
    cfg('1, 0, 3, 1'b0);
    cfg('1, 1, 5, 1'b0);
    run(20, '1);
    hit = 0;
    for (int k = 0; k < 50 && !hit; k++) begin
      if (!m_pend[0] && !m_pend[1] && ((m_n[0] + 1) % (longint'(m_div[0]) + 1) == 0)) begin
        drive('1, 1'b1, 1'b0, 0, 0, 1'b0);
        hit = 1;
      end else begin
        drive('1, 1'b0, 1'b0, 0, 0, 1'b0);
      end
    end
    n_checks++;
    if (hit) n_pass++;
    else $display("FAIL sync_align: got no ch0 wrap within 50 cycles, required one");
    run(14, '1);

    // Out-of-range channel: always ready, nothing changes.
    for (int k = 0; k < 6; k++) drive('1, 1'b0, 1'b1, 3, 0, 1'b1);
    run(10, '1);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      logic [CH-1:0] e;
      for (int b = 0; b < CH; b++) e[b] = ($urandom_range(0, 9) != 0);
      drive(e, ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 3)), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end

    // Reset mid-period: outputs clear without a clock edge.
    run(7, '1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    en    = '0;
    #1;
    check("async_reset_tick", 32'(tick), 32'(0));
    check("async_reset_divided_clk", 32'(divided_clk), 32'(0));
    check("async_reset_cfg_ready", 32'(cfg_ready), 32'(1));
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run(12, '1);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Bank of independent clock dividers generating divided clocks and single-cycle tick enables from the 100 MHz system clock. Each channel's divisor and mode are reprogrammed at run time through a valid/ready configuration port. Changes are applied glitch-free at the channel's next wrap. Replaces fixed-parameter single-channel division wherever display, debounce and game-timing logic need several rates, or rates changed on the fly.

## Interface
- `CHANNELS`, 4: number of divider channels (1..16).
- `DIV_W`, 32: width of divisor and counter.
- `DEFAULT_DIV`, 1: divisor loaded into every channel at reset (fits in `DIV_W`).
- `clk` input 1: system clock, 100 MHz.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input CHANNELS: per-channel run enable.
- `sync` input 1: single-cycle pulse, phase-aligns all channels.
- `cfg_valid` input 1: configuration request.
- `cfg_ready` output 1: configuration can be accepted this cycle.
- `cfg_ch` input $clog2(CHANNELS) (min 1): target channel.
- `cfg_div` input DIV_W: new divisor.
- `cfg_mode` input 1: `0` = TOGGLE, `1` = PULSE.
- `divided_clk` output CHANNELS: divided clock per channel, registered.
- `tick` output CHANNELS: one-cycle enable at each wrap, registered.

## Operation
- Per-channel state:
  - counter `cnt` (DIV_W).
  - active `div` and `mode`.
  - shadow `div` and `mode`, plus a `pending` flag.
- Running (`en[i]`=1), each cycle:
  - If `cnt == div`: `cnt` <- 0 and `tick` <- 1. In TOGGLE mode, `divided_clk` toggles.
  - Otherwise: `cnt` <- `cnt`+1 and `tick` <- 0.
- Output rate:
  - TOGGLE: `divided_clk` period = 2*(div+1) cycles, 50% duty.
  - PULSE: `divided_clk` equals `tick`, i.e. high 1 of every div+1 cycles.
- `div` = 0:
  - TOGGLE gives clk/2.
  - PULSE holds `tick` and `divided_clk` constantly 1.
- Disabled (`en[i]`=0):
  - `cnt`, `tick` and `divided_clk` are forced to 0 on the next edge.
  - After re-enable, the first `tick` occurs div+1 cycles after the first enabled edge.
- Configuration handshake:
  - Transfer occurs when `cfg_valid && cfg_ready`.
  - `cfg_ready` = ~`pending[cfg_ch]`, purely combinational from registered state.
  - On transfer, the shadow registers are loaded and `pending` is set.
  - `cfg_ch` >= CHANNELS: `cfg_ready`=1 and the request is dropped.
- Applying a pending configuration:
  - Applied on the edge where the channel wraps (`cnt == div`), or on the next edge if the channel is disabled, or on `sync`.
  - On that edge: active <- shadow and `pending` cleared.
  - The counter compares against the new `div` starting the following cycle.
- Mode change at apply: `divided_clk` is forced to 0 on the apply edge. TOGGLE then starts a fresh low phase.
- `sync`: every channel gets `cnt` <- 0, `tick` <- 0 and `divided_clk` <- 0, and applies any pending configuration.
- Priority, highest first: reset > `sync` > `en`=0 > wrap/count.
  - `sync` coincident with a wrap: no `tick`.
  - A transfer on the same edge as an apply for that channel is impossible, because `cfg_ready` is low while pending.

## Timing
- Reset values:
  - `divided_clk` = 0, `tick` = 0, `cfg_ready` = 1.
  - All `cnt` = 0, active `div` = DEFAULT_DIV, mode TOGGLE, `pending` = 0.
- `tick` and `divided_clk` are registered; they assert on the edge where `cnt == div` is sampled.
- Config-to-effect latency:
  - Enabled channel: at most div_old+1 cycles.
  - Disabled channel: 1 cycle.
- Reset asserted mid-operation clears all state immediately, with no clock needed. Deassertion is assumed synchronised upstream.
- No combinational path from `en` or `sync` to any output.

## Structure
- Package `clk_div_pkg`:
  - typedef enum `div_mode_e` {`DIV_TOGGLE`, `DIV_PULSE`}.
  - Parameter check constant for CHANNELS <= 16.
- Sub-module `clk_div_channel`: one channel (counter, active and shadow registers, pending flag, outputs).
- Top level: generate loop over `clk_div_channel`, plus the `cfg_ch` decode and `cfg_ready` mux.

## Test plan
- Reset with DEFAULT_DIV=1, all `en`=1 -> every `divided_clk` has period 4 cycles; `tick` every 2 cycles, first `tick` 2 cycles after enable.
- Program ch1 to div=4 PULSE while running at div=1 -> `cfg_ready` low until the next ch1 wrap; afterwards `tick[1]` = `divided_clk[1]`, high 1 of every 5 cycles.
- `cfg_valid` held for ch2 twice back-to-back -> second request stalls (`cfg_ready`=0) until the first is applied; both values are taken in order.
- `en[0]` dropped mid-count with div=9, program div=2, re-enable -> outputs 0 while disabled; config applied 1 cycle after the transfer; first `tick` 3 cycles after re-enable.
- Channels at div 3 and 5 free-running, `sync` pulse coincident with ch0 wrap -> no `tick[0]` that cycle; both channels then produce their first `tick` exactly 4 and 6 cycles later.
- `cfg_ch`=CHANNELS (invalid) -> `cfg_ready`=1 and no channel changes; `rst_n` asserted mid-period -> all outputs 0 immediately.
